ej32_rom_arb: RTL and testbench
===============================

Name: ej32_rom_arb

Overview:
- Sequences and shares the single byte-wide, 1-cycle-latency EBR ROM that holds the host eForth image.
- Serves two requesters:
  - the bytecode fetch port, which reads 1 byte;
  - the data port, which reads 1/2/4 bytes and assembles them big-endian into a 32-bit word.
- Sits between the eJ32 core and the ROM module, and drives the ROM's byte address.
- Arbitration is round-robin, so neither requester starves.

Parameters:
- ASZ, 17, width of requester addresses and rom_a (matches the package address type).
- ROM_SZ, 8192, ROM depth in bytes; informational only, because address truncation happens in the ROM.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  ASZ  fetch byte address.
- f_ack  out  1  one-cycle pulse; f_data is valid in this cycle.
- f_data  out  8  fetched byte.
- d_req  in  1  data-read request; held high until d_ack.
- d_addr  in  ASZ  address of the first (most significant) byte.
- d_sz  in  2  read size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = reserved (treated as 4).
- d_ack  out  1  one-cycle pulse; d_data is valid in this cycle.
- d_data  out  32  read data, zero-extended, big-endian.
- rom_a  out  ASZ  byte address to the ROM.
- rom_d  in  8  ROM read data, valid one cycle after rom_a is presented.
- busy  out  1  high while a transaction is in flight.

Behaviour:
Reset:
- Applies at any clk edge with rst=1.
- Values: state=IDLE, f_ack=0, d_ack=0, f_data=0, d_data=0, rom_a=0, busy=0, last-grant=data (so fetch wins the first tie).
- A reset arriving mid-transaction aborts it: no ack is issued and the accumulator is cleared.
- All requests are ignored while rst=1.

FSM states: IDLE, ISSUE, DRAIN, ACK.

IDLE:
- On an edge with a request present, grant one requester.
- Latch its address into a_r and the byte count into n (1 for fetch; 1/2/4 for data).
- Clear the accumulator, set the issue counter i=0, go to ISSUE.
- Tie (f_req and d_req both high) goes to whichever was not granted last; update last-grant.

ISSUE (one byte address per cycle):
- rom_a = a_r + i; i increments each cycle.
- When i = n-1 has been issued, go to DRAIN.
- The address increments modulo 2^ASZ; the ROM wraps it further to its depth.

Return path (active in ISSUE and DRAIN):
- Each cycle after a byte's address was presented, shift it in: acc = {acc[23:0], rom_d}.
- DRAIN lasts exactly one cycle and captures the final byte, then goes to ACK.

ACK (registered outputs, one cycle):
- Pulse f_ack or d_ack for the granted requester and drive f_data/d_data from acc.
- The other ack stays 0. Return to IDLE; busy drops in that IDLE cycle.
- The data outputs hold their value until the next ack.

Latency:
- With the request sampled at edge 0, the ack pulses in cycle n+2: fetch in cycle 3, 4-byte read in cycle 6.
- Back-to-back: a request held in the ack cycle is granted at the next IDLE edge. Throughput is one transaction per n+3 cycles.

Handshake rules:
- Once a request is granted, its address and size are latched; later input changes have no effect on that transaction.
- Deasserting req after grant still completes the transaction and pulses ack.
- A req that stays high after ack is treated as a new request.

Other rules:
- busy = (state != IDLE).
- rom_a holds its last value in IDLE.

Decomposition:
- ej32_pkg gains:
  - the read-size enum (SZ_B, SZ_H, SZ_W);
  - the arbiter state enum;
  - a function mapping size to byte count.
- One natural sub-module, ej32_rom_seq:
  - owns the issue counter, address increment and big-endian accumulator;
  - is started by the top-level arbiter with (addr, n), and reports done.
- The top level keeps arbitration, last-grant and ack steering.

Test Plan:
1. ROM preloaded with byte[k] = k[7:0]; f_req, f_addr=0x0010 -> f_ack in cycle 3, f_data=0x10; rom_a=0x0010 during ISSUE.
2. d_req, d_addr=0x0100, d_sz=2 -> d_ack in cycle 6, d_data=0x00010203; d_sz=1 at 0x01FE -> 0x0000FEFF; d_sz=0 at 0x0005 -> 0x00000005.
3. f_req and d_req rise together and stay high -> grants alternate fetch, data, fetch, data; neither ack is ever high in the same cycle as the other; no starvation over 8 transactions.
4. d_addr=2^ASZ-2, d_sz=2 -> bytes read from addresses 1FFFE, 1FFFF, 00000, 00001; d_data matches those ROM bytes.
5. rst=1 in the second ISSUE cycle of a 4-byte read -> no d_ack; all outputs return to reset values on the next edge; a new f_req after reset completes normally with f_ack in cycle 3.
6. f_addr changed and f_req dropped the cycle after grant -> f_ack still pulses in cycle 3 with the byte at the latched address.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 ROM path.
// Provides the data-port read-size encoding, the ROM arbiter state type and a
// helper that maps a read size to the number of bytes fetched from the ROM.
package ej32_pkg;

  localparam int unsigned ADDR_W = 17;

  typedef logic [ADDR_W-1:0] addr_t;

  // Data-port read size; encoding 2'd3 is reserved and reads 4 bytes.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } rd_sz_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StAck
  } arb_st_e;

  function automatic logic [2:0] sz_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ej32_rom_seq.sv
// Byte sequencer for the shared 1-cycle-latency ROM.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load addr/n, clear the accumulator and restart the issue counter
//   addr, n    first byte address and byte count (1, 2 or 4)
//   issue      high while the arbiter is in its issue state
//   done       the last byte address of the transaction is being presented
//   rom_a      byte address to the ROM (held when not issuing)
//   rom_d      ROM read data, valid one cycle after rom_a
//   acc        big-endian accumulator of returned bytes
module ej32_rom_seq
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] addr,
  input  logic [2:0]     n,
  input  logic           issue,
  output logic           done,
  output logic [ASZ-1:0] rom_a,
  input  logic [7:0]     rom_d,
  output logic [31:0]    acc
);

  logic [ASZ-1:0] base_q;
  logic [ASZ-1:0] rom_a_q;
  logic [1:0]     last_q;
  logic [1:0]     idx_q;
  logic [1:0]     idx_d;
  logic           vld_q;
  logic [31:0]    acc_q;

  assign idx_d = idx_q + 2'd1;
  assign done  = issue && (idx_q == last_q);
  assign rom_a = rom_a_q;
  assign acc   = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      rom_a_q <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      // A byte addressed in an issue cycle is on rom_d during the next cycle.
      vld_q <= issue;
      if (start) begin
        base_q  <= addr;
        rom_a_q <= addr;
        last_q  <= 2'(n - 3'd1);
        idx_q   <= '0;
        acc_q   <= '0;
      end else begin
        if (issue && !done) begin
          idx_q   <= idx_d;
          // Wraps modulo 2^ASZ; the ROM applies its own depth wrap.
          rom_a_q <= base_q + ASZ'(idx_d);
        end
        if (vld_q) begin
          acc_q <= {acc_q[23:0], rom_d};
        end
      end
    end
  end

endmodule

// File: rtl/ej32_rom_arb.sv
// Round-robin arbiter sharing the byte-wide eForth image ROM between the
// bytecode fetch port (1 byte) and the data port (1/2/4 bytes, big-endian).
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   f_req/f_addr          fetch request and byte address
//   f_ack/f_data          one-cycle ack pulse and fetched byte (held until next ack)
//   d_req/d_addr/d_sz     data request, first-byte address and size
//   d_ack/d_data          one-cycle ack pulse and zero-extended word (held until next ack)
//   rom_a/rom_d           ROM byte address and 1-cycle-latency read data
//   busy                  a transaction is in flight
module ej32_rom_arb
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ    = 17,
  parameter int unsigned ROM_SZ = 8192
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           f_req,
  input  logic [ASZ-1:0] f_addr,
  output logic           f_ack,
  output logic [7:0]     f_data,
  input  logic           d_req,
  input  logic [ASZ-1:0] d_addr,
  input  logic [1:0]     d_sz,
  output logic           d_ack,
  output logic [31:0]    d_data,
  output logic [ASZ-1:0] rom_a,
  input  logic [7:0]     rom_d,
  output logic           busy
);

  // The ROM truncates addresses itself; only reject a ROM the address cannot reach.
  if (ROM_SZ > (64'd1 << ASZ)) begin : g_rom_sz_check
    $error("ROM_SZ exceeds the ASZ address space");
  end

  arb_st_e        state_q, state_d;
  logic           last_data_q, last_data_d;  // last grant went to the data port
  logic           grant_fetch;
  logic           start;
  logic           ack_now;
  logic           seq_done;
  logic [ASZ-1:0] start_addr;
  logic [2:0]     start_n;
  logic [31:0]    acc;

  logic           f_ack_q;
  logic           d_ack_q;
  logic [7:0]     f_data_q;
  logic [31:0]    d_data_q;

  ej32_rom_seq #(
    .ASZ (ASZ)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .addr  (start_addr),
    .n     (start_n),
    .issue (state_q == StIssue),
    .done  (seq_done),
    .rom_a (rom_a),
    .rom_d (rom_d),
    .acc   (acc)
  );

  // On a tie, fetch wins only if data was granted last.
  assign grant_fetch = f_req && (!d_req || last_data_q);
  assign start_addr  = grant_fetch ? f_addr : d_addr;
  assign start_n     = grant_fetch ? 3'd1 : sz_bytes(d_sz);
  assign ack_now     = (state_q == StAck);

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    start       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (f_req || d_req) begin
          start       = 1'b1;
          last_data_d = !grant_fetch;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (seq_done) state_d = StDrain;
      end
      StDrain: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_data_q <= 1'b1;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_data_q    <= '0;
      d_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      // last_data_q still names the in-flight requester while in StAck.
      f_ack_q     <= ack_now && !last_data_q;
      d_ack_q     <= ack_now && last_data_q;
      if (ack_now && !last_data_q) f_data_q <= acc[7:0];
      if (ack_now && last_data_q)  d_data_q <= acc;
    end
  end

  assign f_ack  = f_ack_q;
  assign d_ack  = d_ack_q;
  assign f_data = f_data_q;
  assign d_data = d_data_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_ej32_rom_arb.sv
// Directed self-checking bench for ej32_rom_arb with a byte[k] = k[7:0] ROM model.
module tb_ej32_rom_arb;

  localparam int unsigned ASZ = 17;

  logic           clk = 1'b0;
  logic           rst;
  logic           f_req;
  logic [ASZ-1:0] f_addr;
  logic           f_ack;
  logic [7:0]     f_data;
  logic           d_req;
  logic [ASZ-1:0] d_addr;
  logic [1:0]     d_sz;
  logic           d_ack;
  logic [31:0]    d_data;
  logic [ASZ-1:0] rom_a;
  logic [7:0]     rom_d = 8'h00;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  ej32_rom_arb #(
    .ASZ    (ASZ),
    .ROM_SZ (8192)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .f_req  (f_req),
    .f_addr (f_addr),
    .f_ack  (f_ack),
    .f_data (f_data),
    .d_req  (d_req),
    .d_addr (d_addr),
    .d_sz   (d_sz),
    .d_ack  (d_ack),
    .d_data (d_data),
    .rom_a  (rom_a),
    .rom_d  (rom_d),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency ROM, 8 KiB deep, byte[k] = k[7:0].
  always @(posedge clk) rom_d <= rom_a[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raise one request now; edge 0 is the next rising edge; ack due in cycle n+2.
  task automatic do_txn(input bit fetch, input logic [ASZ-1:0] addr, input logic [1:0] sz,
                        input int n, input logic [31:0] exp, input string tag);
    logic [ASZ-1:0] a;
    if (fetch) begin
      f_addr = addr;
      f_req  = 1'b1;
    end else begin
      d_addr = addr;
      d_sz   = sz;
      d_req  = 1'b1;
    end
    for (int k = 0; k <= n + 2; k++) begin
      cyc();
      a = addr + ASZ'(k);
      if (k == 0) chk({tag, " busy"}, 32'(busy), 32'd1);
      if (k < n) chk({tag, " rom_a"}, 32'(rom_a), 32'(a));
      if (k < n + 2) begin
        chk({tag, " early ack"}, 32'(fetch ? f_ack : d_ack), 32'd0);
      end else begin
        chk({tag, " ack"}, 32'(fetch ? f_ack : d_ack), 32'd1);
        chk({tag, " other ack"}, 32'(fetch ? d_ack : f_ack), 32'd0);
        chk({tag, " data"}, fetch ? 32'(f_data) : d_data, exp);
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        f_req = 1'b0;
        d_req = 1'b0;
      end
    end
  endtask

  initial begin
    int acks;
    rst    = 1'b1;
    f_req  = 1'b0;
    d_req  = 1'b0;
    f_addr = '0;
    d_addr = '0;
    d_sz   = 2'd0;
    repeat (2) cyc();
    chk("rst f_ack", 32'(f_ack), 32'd0);
    chk("rst d_ack", 32'(d_ack), 32'd0);
    chk("rst f_data", 32'(f_data), 32'd0);
    chk("rst d_data", d_data, 32'd0);
    chk("rst rom_a", 32'(rom_a), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single transactions.
    do_txn(1'b1, 17'h00010, 2'd0, 1, 32'h0000_0010, "fetch 0010");
    do_txn(1'b0, 17'h00100, 2'd2, 4, 32'h0001_0203, "word 0100");
    do_txn(1'b0, 17'h001FE, 2'd1, 2, 32'h0000_FEFF, "half 01FE");
    do_txn(1'b0, 17'h00005, 2'd0, 1, 32'h0000_0005, "byte 0005");
    do_txn(1'b0, 17'h00040, 2'd3, 4, 32'h4041_4243, "rsvd sz 0040");

    // Both requests held high: grants alternate, fetch first.
    f_addr = 17'h00020;
    d_addr = 17'h00030;
    d_sz   = 2'd1;
    f_req  = 1'b1;
    d_req  = 1'b1;
    acks   = 0;
    for (int c = 0; c < 80 && acks < 8; c++) begin
      cyc();
      chk("tie dual ack", 32'(f_ack & d_ack), 32'd0);
      if (f_ack || d_ack) begin
        chk("tie order", 32'(d_ack), 32'(acks % 2));
        if (d_ack) chk("tie d_data", d_data, 32'h0000_3031);
        else       chk("tie f_data", 32'(f_data), 32'h0000_0020);
        acks++;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    chk("tie count", 32'(acks), 32'd8);
    repeat (6) cyc();
    chk("tie drained", 32'(busy), 32'd0);

    // Address wrap at the top of the address space.
    do_txn(1'b0, 17'h1FFFE, 2'd2, 4, 32'hFEFF_0001, "wrap 1FFFE");

    // Inputs change after grant: latched address still used.
    f_addr = 17'h00042;
    f_req  = 1'b1;
    cyc();
    f_addr = 17'h00077;
    f_req  = 1'b0;
    chk("latch busy", 32'(busy), 32'd1);
    cyc();
    chk("latch early ack1", 32'(f_ack), 32'd0);
    cyc();
    chk("latch early ack2", 32'(f_ack), 32'd0);
    cyc();
    chk("latch ack", 32'(f_ack), 32'd1);
    chk("latch data", 32'(f_data), 32'h0000_0042);
    cyc();
    chk("latch ack pulse", 32'(f_ack), 32'd0);
    chk("latch idle", 32'(busy), 32'd0);
    chk("latch hold", 32'(f_data), 32'h0000_0042);

    // Reset in the second issue cycle of a 4-byte read.
    d_addr = 17'h00100;
    d_sz   = 2'd2;
    d_req  = 1'b1;
    cyc();
    chk("abort busy", 32'(busy), 32'd1);
    cyc();
    chk("abort rom_a", 32'(rom_a), 32'h0000_0101);
    rst   = 1'b1;
    d_req = 1'b0;
    cyc();
    chk("abort f_ack", 32'(f_ack), 32'd0);
    chk("abort d_ack", 32'(d_ack), 32'd0);
    chk("abort f_data", 32'(f_data), 32'd0);
    chk("abort d_data", d_data, 32'd0);
    chk("abort rom_a rst", 32'(rom_a), 32'd0);
    chk("abort busy rst", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("abort no d_ack", 32'(d_ack), 32'd0);
      chk("abort stays idle", 32'(busy), 32'd0);
    end
    do_txn(1'b1, 17'h00033, 2'd0, 1, 32'h0000_0033, "post-rst fetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
